// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing, 12-bit distance in mm (12'hFFF = invalid).
// Build option RANGER_AVG4_EN: publish the running average of the last four results instead of the raw one.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int PERIOD_CYCLES = 3000000,
  parameter int CYCLES_PER_MM = 291,
  parameter int WAIT_CYCLES   = 1000000,
  parameter int MAX_MM        = 4000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] binary_dst,
  output logic        dst_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int PW = 22;
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int SW = $clog2(CYCLES_PER_MM + 1);
  localparam logic [11:0] DST_INVALID = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  state_t        state_r;
  logic          echo_meta_r;
  logic          echo_sync_r;
  logic          echo_prev_r;
  logic [PW-1:0] period_cnt_r;
  logic          pending_r;
  logic [TW-1:0] trig_cnt_r;
  logic [WW-1:0] wait_cnt_r;
  logic [SW-1:0] presc_r;
  logic [11:0]   mm_r;
  logic          trig_r;
  logic          busy_r;
  logic          pub_valid_r;
  logic          pub_to_r;
  logic [11:0]   pub_dst_r;

  logic          echo_rise_s;
  logic          period_wrap_s;
  logic          consume_s;
  logic          presc_last_s;
  logic [11:0]   mm_inc_s;

  assign echo_rise_s   = echo_sync_r & ~echo_prev_r;
  assign period_wrap_s = (period_cnt_r == PW'(PERIOD_CYCLES - 1));
  assign consume_s     = (state_r == ST_IDLE) && pending_r;
  assign presc_last_s  = (presc_r == SW'(CYCLES_PER_MM - 1));
  assign mm_inc_s      = mm_r + 12'd1;

  // Two-flop synchronizer for the echo pin plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= echo_sync_r;
    end
  end

  // Free-running measurement period; a wrap raises pending until IDLE consumes it
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_cnt_r <= PW'(0);
      pending_r    <= 1'b1;
    end else begin
      period_cnt_r <= period_wrap_s ? PW'(0) : period_cnt_r + PW'(1);
      if (period_wrap_s) begin
        pending_r <= 1'b1;
      end else if (consume_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Ranging FSM with registered trigger, busy and per-measurement result
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= ST_IDLE;
      trig_r      <= 1'b0;
      busy_r      <= 1'b0;
      trig_cnt_r  <= TW'(0);
      wait_cnt_r  <= WW'(0);
      presc_r     <= SW'(0);
      mm_r        <= 12'd0;
      pub_valid_r <= 1'b0;
      pub_to_r    <= 1'b0;
      pub_dst_r   <= DST_INVALID;
    end else begin
      pub_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            state_r    <= ST_TRIG;
            trig_r     <= 1'b1;
            busy_r     <= 1'b1;
            trig_cnt_r <= TW'(0);
          end
        end
        ST_TRIG: begin
          if (trig_cnt_r == TW'(TRIG_CYCLES - 1)) begin
            trig_r     <= 1'b0;
            wait_cnt_r <= WW'(0);
            state_r    <= ST_WAIT_ECHO;
          end else begin
            trig_cnt_r <= trig_cnt_r + TW'(1);
          end
        end
        ST_WAIT_ECHO: begin
          if (echo_rise_s) begin
            // The edge cycle is itself the first echo-high cycle
            presc_r <= SW'(1 % CYCLES_PER_MM);
            mm_r    <= 12'(1 / CYCLES_PER_MM);
            state_r <= ST_MEASURE;
          end else if (wait_cnt_r == WW'(WAIT_CYCLES - 1)) begin
            pub_valid_r <= 1'b1;
            pub_to_r    <= 1'b1;
            pub_dst_r   <= DST_INVALID;
            state_r     <= ST_HOLDOFF;
          end else begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end
        end
        ST_MEASURE: begin
          if (!echo_sync_r) begin
            pub_valid_r <= 1'b1;
            pub_to_r    <= 1'b0;
            pub_dst_r   <= mm_r;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (presc_last_s) begin
            presc_r <= SW'(0);
            if (mm_inc_s == 12'(MAX_MM)) begin
              pub_valid_r <= 1'b1;
              pub_to_r    <= 1'b1;
              pub_dst_r   <= DST_INVALID;
              state_r     <= ST_HOLDOFF;
            end else begin
              mm_r <= mm_inc_s;
            end
          end else begin
            presc_r <= presc_r + SW'(1);
          end
        end
        ST_HOLDOFF: begin
          if (!echo_sync_r) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          trig_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign trig = trig_r;
  assign busy = busy_r;

`ifdef RANGER_AVG4_EN
  // Three previous results; the incoming result is the fourth history entry
  logic [11:0] hist_r [0:2];
  logic [13:0] sum_s;
  logic [11:0] avg_dst_r;
  logic        avg_valid_r;
  logic        avg_to_r;

  assign sum_s = 14'(pub_dst_r) + 14'(hist_r[0]) + 14'(hist_r[1]) + 14'(hist_r[2]);

  // Shift each new result into the history and register the averaged output
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist_r[0]   <= DST_INVALID;
      hist_r[1]   <= DST_INVALID;
      hist_r[2]   <= DST_INVALID;
      avg_dst_r   <= DST_INVALID;
      avg_valid_r <= 1'b0;
      avg_to_r    <= 1'b0;
    end else begin
      avg_valid_r <= pub_valid_r;
      if (pub_valid_r) begin
        hist_r[0] <= pub_dst_r;
        hist_r[1] <= hist_r[0];
        hist_r[2] <= hist_r[1];
        avg_dst_r <= sum_s[13:2];
        avg_to_r  <= pub_to_r;
      end
    end
  end

  assign binary_dst = avg_dst_r;
  assign dst_valid  = avg_valid_r;
  assign timeout    = avg_to_r;
`else
  assign binary_dst = pub_dst_r;
  assign dst_valid  = pub_valid_r;
  assign timeout    = pub_to_r;
`endif

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: table of echo widths plus hand sequences for
// timeouts, holdoff, pending-period carry-over and asynchronous reset.
module tb_ultrasonic_ranger;

  localparam int TRIG_CYCLES   = 5;
  localparam int PERIOD_CYCLES = 4000;
  localparam int CYCLES_PER_MM = 3;
  localparam int WAIT_CYCLES   = 200;
  localparam int MAX_MM        = 1000;
`ifdef RANGER_AVG4_EN
  localparam int XLAT = 1;
`else
  localparam int XLAT = 0;
`endif

  typedef struct {
    int          delay;
    int          high;
    logic [11:0] dst;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [11:0] binary_dst;
  logic        dst_valid;
  logic        timeout;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES  (TRIG_CYCLES),
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .CYCLES_PER_MM(CYCLES_PER_MM),
    .WAIT_CYCLES  (WAIT_CYCLES),
    .MAX_MM       (MAX_MM)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .echo      (echo),
    .trig      (trig),
    .binary_dst(binary_dst),
    .dst_valid (dst_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_trig_rise(input string name, output int at);
    int n = 0;
    while (trig !== 1'b1 && n < 9000) begin
      tick();
      n++;
    end
    check(name, trig, 1);
    at = cyc;
  endtask

  task automatic wait_trig_fall();
    int n = 0;
    while (trig === 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Starts with trig just risen; echo rises `delay` cycles after trig falls
  task automatic echo_pulse(input string name, input int delay, input int high,
                            input logic [11:0] exp_dst);
    logic early;
    wait_trig_fall();
    repeat (delay - 1) tick();
    echo = 1'b1;
    repeat (high) tick();
    check({name, "_busy"}, busy, 1);
    echo = 1'b0;
    early = 1'b0;
    repeat (2 + XLAT) begin
      tick();
      early = early | dst_valid;
    end
    check({name, "_early"}, early, 0);
    tick();
    check({name, "_valid"}, dst_valid, 1);
    check({name, "_dst"}, binary_dst, exp_dst);
    check({name, "_to"}, timeout, 0);
    tick();
    check({name, "_strobe"}, dst_valid, 0);
  endtask

  initial begin
    vec_t vecs [3];
    int   t_prev;
    int   t_now;
    int   t_ref;
    int   hi;
    int   ntrig;
    logic [11:0] hist [4];

    vecs[0] = '{100, 300, 12'd100};
    vecs[1] = '{100, 2,   12'd0};
    vecs[2] = '{100, 302, 12'd100};

    // reset state and first trigger
    repeat (3) tick();
    check("rst_dst", binary_dst, 12'hFFF);
    check("rst_valid", dst_valid, 0);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_to", timeout, 0);
    n_rst = 1'b1;
    tick();
    check("trig_first", trig, 1);
    t_prev = cyc;
    hi = 0;
    while (trig === 1'b1 && hi < 50) begin
      hi++;
      tick();
    end
    check("trig_width", hi, TRIG_CYCLES);

    // no echo: timeout WAIT_CYCLES after trig falls
    repeat (WAIT_CYCLES - 1 + XLAT) tick();
    check("noecho_early", dst_valid, 0);
    tick();
    check("noecho_valid", dst_valid, 1);
    check("noecho_dst", binary_dst, 12'hFFF);
    check("noecho_to", timeout, 1);
    wait_trig_rise("trig_second", t_now);
    check("trig_period", t_now - t_prev, PERIOD_CYCLES);

`ifdef RANGER_AVG4_EN
    for (int k = 0; k < 4; k++) hist[k] = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      int sum;
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = 12'((i + 1) * 100);
      sum = 0;
      for (int k = 0; k < 4; k++) sum += int'(hist[k]);
      echo_pulse($sformatf("avg%0d", i), 100, (i + 1) * 300, 12'(sum >> 2));
      wait_trig_rise($sformatf("avg%0d_next", i), t_now);
    end
`else
    hist[0] = 12'd0;
    for (int i = 0; i < 3; i++) begin
      echo_pulse($sformatf("vec%0d", i), vecs[i].delay, vecs[i].high, vecs[i].dst);
      wait_trig_rise($sformatf("vec%0d_next", i), t_now);
    end

    // asynchronous reset in the middle of MEASURE
    wait_trig_fall();
    repeat (99) tick();
    echo = 1'b1;
    repeat (600) tick();
    check("mid_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_trig", trig, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dst", binary_dst, 12'hFFF);
    check("mid_rst_valid", dst_valid, 0);
    echo = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    check("rst_retrig", trig, 1);
    echo_pulse("post_rst", 100, 300, 12'd100);

    // echo already high through the trigger: no rising edge, so timeout
    echo = 1'b1;
    wait_trig_rise("stuck_trig", t_now);
    wait_trig_fall();
    repeat (WAIT_CYCLES - 1) tick();
    check("stuck_early", dst_valid, 0);
    tick();
    check("stuck_valid", dst_valid, 1);
    check("stuck_dst", binary_dst, 12'hFFF);
    check("stuck_to", timeout, 1);
    repeat (10) tick();
    check("stuck_holdoff_busy", busy, 1);
    echo = 1'b0;
    repeat (2) tick();
    check("stuck_holdoff_still", busy, 1);
    tick();
    check("stuck_idle", busy, 0);

    // long echo: MAX_MM timeout, holdoff across a period wrap, pending re-trigger
    wait_trig_rise("long_trig", t_ref);
    wait_trig_fall();
    repeat (99) tick();
    echo = 1'b1;
    repeat (3001) tick();
    check("max_early", dst_valid, 0);
    tick();
    check("max_valid", dst_valid, 1);
    check("max_dst", binary_dst, 12'hFFF);
    check("max_to", timeout, 1);
    ntrig = 0;
    repeat (5000 - 3002) begin
      tick();
      if (trig === 1'b1) ntrig++;
    end
    check("holdoff_no_trig", ntrig, 0);
    echo = 1'b0;
    repeat (3) tick();
    check("holdoff_wait", trig, 0);
    tick();
    check("pending_reissue", trig, 1);
    wait_trig_fall();
    wait_trig_rise("grid_trig", t_now);
    check("grid_period", t_now - t_ref, 2 * PERIOD_CYCLES);

    // period wrap while busy with a 3990-cycle echo
    t_ref = t_now;
    wait_trig_fall();
    repeat (99) tick();
    echo = 1'b1;
    repeat (3001) tick();
    check("wrap_early", dst_valid, 0);
    tick();
    check("wrap_valid", dst_valid, 1);
    check("wrap_to", timeout, 1);
    repeat (3990 - 3002) tick();
    echo = 1'b0;
    repeat (3) tick();
    check("wrap_wait", trig, 0);
    tick();
    check("wrap_reissue", trig, 1);
    wait_trig_fall();
    wait_trig_rise("wrap_grid_trig", t_now);
    check("wrap_period", t_now - t_ref, 2 * PERIOD_CYCLES);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
